// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall/flush requests from the datapath and the
// resulting per-stage hold, flush and redirect controls.
interface pipe_ctrl_if;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [7:0]  stall_cnt_o;
  logic        timeout_o;
  logic [1:0]  state_dbg;

  // Requests are level/pulse qualified per cycle; there is no valid/ready
  // handshake: the controller samples them every rising edge, and a flush
  // request arriving while a flush is already in progress is simply dropped.
  modport master (
    output stallreq_id_i, stallreq_ex_i, flush_req_i, flush_pc_i,
    input  stall_o, flush_o, new_pc_o, stall_cnt_o, timeout_o, state_dbg
  );
  modport slave (
    input  stallreq_id_i, stallreq_ex_i, flush_req_i, flush_pc_i,
    output stall_o, flush_o, new_pc_o, stall_cnt_o, timeout_o, state_dbg
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with RUN/STALL/FLUSH/DRAIN sequencing.
// Define PIPE_CTRL_WATCHDOG_EN to compile in the stall watchdog.
module pipe_ctrl #(
  parameter logic [7:0]  WDOG_LIMIT  = 8'd64,
  parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, DRAIN} state_t;

`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  state_t      state;
  logic [31:0] target_q;
  logic [7:0]  cnt_q;
  logic        timeout_q;
  logic        active;
  logic        any_req;
  logic        wdog_fire;
  logic [5:0]  stall_vec;

  always_comb begin
    active    = (state == RUN) || (state == STALL);
    any_req   = bus.stallreq_id_i || bus.stallreq_ex_i;
    wdog_fire = WDOG_EN && (state == STALL) && (cnt_q == WDOG_LIMIT);
    stall_vec = 6'b000000;
    if (bus.stallreq_ex_i)
      stall_vec = 6'b001111;
    else if (bus.stallreq_id_i)
      stall_vec = 6'b000111;
  end

  // stall_o is combinational on the requests; rst gates it so reset clears it at once.
  always_comb begin
    bus.stall_o = 6'b000000;
    if (active && !bus.flush_req_i && !rst)
      bus.stall_o = stall_vec;
  end

  assign bus.flush_o     = (state == FLUSH);
  assign bus.new_pc_o    = (state == FLUSH) ? target_q : 32'h0000_0000;
  assign bus.stall_cnt_o = cnt_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.state_dbg   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      target_q  <= 32'h0000_0000;
      cnt_q     <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        RUN, STALL: begin
          if (bus.flush_req_i) begin
            // An explicit redirect wins over the watchdog target, but the timeout still reports.
            state     <= FLUSH;
            target_q  <= bus.flush_pc_i;
            timeout_q <= wdog_fire;
            cnt_q     <= 8'h00;
          end else if (wdog_fire) begin
            state     <= FLUSH;
            target_q  <= WDOG_VECTOR;
            timeout_q <= 1'b1;
            cnt_q     <= 8'h00;
          end else if (any_req) begin
            state <= STALL;
            if (cnt_q != 8'hFF)
              cnt_q <= cnt_q + 8'd1;
          end else begin
            state <= RUN;
            cnt_q <= 8'h00;
          end
        end
        FLUSH: begin
          state <= DRAIN;
          cnt_q <= 8'h00;
        end
        default: begin
          state <= RUN;
          cnt_q <= 8'h00;
        end
      endcase
    end
  end

endmodule
